// File: rtl/pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_ramp_sequencer
//
// Slew-rate limiter that sits in front of a PWM generator. The duty word
// walks toward an unsigned target in StepSize increments, one step every
// StepPeriods PWM periods, using the generator's period-start pulse
// (i_synch) as the timebase. This gives soft-start and soft-stop. A Stop
// level forces the duty word to zero immediately.
//
// Parameters
//   Size        : width of target and duty words (unsigned)
//   StepSize    : duty change per step, 1 .. 2**Size-1
//   StepPeriods : number of i_synch pulses per step, >= 1
//
// Ports
//   i_clock      in   1     system clock, rising edge
//   i_reset      in   1     synchronous, active-high reset
//   i_target     in   Size  requested duty, sampled every cycle
//   i_synch      in   1     one-cycle pulse at each PWM period start
//   i_enable     in   1     1 = ramping allowed, 0 = freeze everything
//   i_stop       in   1     level, highest priority, forces duty to 0
//   o_duty       out  Size  duty word to the PWM generator
//   o_busy       out  1     1 while ramping (UP or DOWN)
//   o_at_target  out  1     1 when holding and duty equals target
//   o_state      out  2     current FSM state, for observation
//                           (0 HOLD, 1 UP, 2 DOWN, 3 STOPPED)
// ---------------------------------------------------------------------------
module pwm_ramp_sequencer #(
    parameter int Size        = 5,
    parameter int StepSize    = 1,
    parameter int StepPeriods = 4
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic [Size-1:0] i_target,
    input  logic            i_synch,
    input  logic            i_enable,
    input  logic            i_stop,
    output logic [Size-1:0] o_duty,
    output logic            o_busy,
    output logic            o_at_target,
    output logic [1:0]      o_state
);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_UP      = 2'd1,
        ST_DOWN    = 2'd2,
        ST_STOPPED = 2'd3
    } state_t;

    // Counter holds 0 .. StepPeriods-1; keep at least one bit.
    localparam int CW = (StepPeriods > 1) ? $clog2(StepPeriods) : 1;

    localparam logic [Size:0] LP_STEP    = (Size + 1)'(StepSize);
    localparam logic [CW:0]   LP_PERIODS = (CW + 1)'(StepPeriods);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t          r_state;
    logic [Size-1:0] r_duty;
    logic [CW-1:0]   r_cnt;
    logic            r_busy;
    logic            r_at_target;

    // -----------------------------------------------------------------------
    // Step arithmetic, one bit wider than the duty word so that neither the
    // sum nor the difference can wrap before it is clamped to the target.
    // -----------------------------------------------------------------------
    logic [Size:0]   w_sum;
    logic [Size:0]   w_diff;
    logic [Size-1:0] w_up_duty;
    logic [Size-1:0] w_down_duty;
    logic [CW:0]     w_cnt_inc;
    logic            w_step_due;

    assign w_sum  = {1'b0, r_duty} + LP_STEP;
    assign w_diff = {1'b0, r_duty} - LP_STEP;

    // min(duty + step, target)
    assign w_up_duty = (w_sum > {1'b0, i_target}) ? i_target : w_sum[Size-1:0];

    // max(duty - step, target); a set top bit means the subtraction went
    // below zero, which is certainly below the target.
    assign w_down_duty = (w_diff[Size] || (w_diff[Size-1:0] < i_target))
                         ? i_target : w_diff[Size-1:0];

    assign w_cnt_inc  = {1'b0, r_cnt} + (CW + 1)'(1);
    assign w_step_due = i_synch && (w_cnt_inc == LP_PERIODS);

    // -----------------------------------------------------------------------
    // Next-state computation. Busy and AtTarget are derived from the next
    // state/duty so that, once registered, they describe the same cycle as
    // the registered state and duty.
    // -----------------------------------------------------------------------
    state_t          w_nstate;
    logic [Size-1:0] w_nduty;
    logic [CW-1:0]   w_ncnt;
    logic            w_nbusy;
    logic            w_nat_target;

    always_comb begin
        w_nstate = r_state;
        w_nduty  = r_duty;
        w_ncnt   = r_cnt;

        if (i_stop) begin
            w_nstate = ST_STOPPED;
            w_nduty  = '0;
            w_ncnt   = '0;
        end else if (!i_enable) begin
            // Frozen: state, duty and counter keep their values and any
            // synch pulse in this cycle is simply not counted.
            w_nstate = r_state;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (i_target > r_duty) begin
                        w_nstate = ST_UP;
                        w_ncnt   = '0;
                    end else if (i_target < r_duty) begin
                        w_nstate = ST_DOWN;
                        w_ncnt   = '0;
                    end
                end

                ST_UP: begin
                    if (i_target == r_duty) begin
                        w_nstate = ST_HOLD;
                        w_ncnt   = '0;
                    end else if (w_step_due) begin
                        w_ncnt = '0;
                        if (i_target < r_duty) begin
                            // Target crossed below: turn around, no step.
                            w_nstate = ST_DOWN;
                        end else begin
                            w_nduty = w_up_duty;
                            if (w_up_duty == i_target) begin
                                w_nstate = ST_HOLD;
                            end
                        end
                    end else if (i_synch) begin
                        w_ncnt = w_cnt_inc[CW-1:0];
                    end
                end

                ST_DOWN: begin
                    if (i_target == r_duty) begin
                        w_nstate = ST_HOLD;
                        w_ncnt   = '0;
                    end else if (w_step_due) begin
                        w_ncnt = '0;
                        if (i_target > r_duty) begin
                            // Target crossed above: turn around, no step.
                            w_nstate = ST_UP;
                        end else begin
                            w_nduty = w_down_duty;
                            if (w_down_duty == i_target) begin
                                w_nstate = ST_HOLD;
                            end
                        end
                    end else if (i_synch) begin
                        w_ncnt = w_cnt_inc[CW-1:0];
                    end
                end

                ST_STOPPED: begin
                    // Duty is already 0; ramping resumes from HOLD.
                    w_nstate = ST_HOLD;
                    w_ncnt   = '0;
                end

                default: begin
                    w_nstate = ST_HOLD;
                    w_nduty  = '0;
                    w_ncnt   = '0;
                end
            endcase
        end

        w_nbusy      = (w_nstate == ST_UP) || (w_nstate == ST_DOWN);
        w_nat_target = (w_nstate == ST_HOLD) && (w_nduty == i_target);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= ST_HOLD;
            r_duty      <= '0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_at_target <= 1'b0;
        end else begin
            r_state     <= w_nstate;
            r_duty      <= w_nduty;
            r_cnt       <= w_ncnt;
            r_busy      <= w_nbusy;
            r_at_target <= w_nat_target;
        end
    end

    assign o_duty      = r_duty;
    assign o_busy      = r_busy;
    assign o_at_target = r_at_target;
    assign o_state     = r_state;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for pwm_ramp_sequencer with Size 5,
// StepSize 3, StepPeriods 2. Inputs change 1 ns after a rising edge and
// outputs are checked at the same point, so every check sees the values
// registered on the edge just taken.
// ---------------------------------------------------------------------------
module tb_pwm_ramp_sequencer;

    localparam int SIZE = 5;

    localparam logic [1:0] S_HOLD    = 2'd0;
    localparam logic [1:0] S_UP      = 2'd1;
    localparam logic [1:0] S_DOWN    = 2'd2;
    localparam logic [1:0] S_STOPPED = 2'd3;

    logic            clk;
    logic            i_reset;
    logic [SIZE-1:0] i_target;
    logic            i_synch;
    logic            i_enable;
    logic            i_stop;
    logic [SIZE-1:0] o_duty;
    logic            o_busy;
    logic            o_at_target;
    logic [1:0]      o_state;

    int n_tests;
    int n_fail;

    pwm_ramp_sequencer #(
        .Size       (SIZE),
        .StepSize   (3),
        .StepPeriods(2)
    ) dut (
        .i_clock    (clk),
        .i_reset    (i_reset),
        .i_target   (i_target),
        .i_synch    (i_synch),
        .i_enable   (i_enable),
        .i_stop     (i_stop),
        .o_duty     (o_duty),
        .o_busy     (o_busy),
        .o_at_target(o_at_target),
        .o_state    (o_state)
    );

    // ---------------------------------------------------------------- clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------- drivers
    // One clock cycle with the given synch value; returns 1 ns after the edge.
    task automatic cycle(input logic synch);
        i_synch = synch;
        @(posedge clk);
        #1;
        i_synch = 1'b0;
    endtask

    // n synch pulses, each followed by one idle cycle.
    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cycle(1'b0);
        cycle(1'b0);
        i_reset = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        i_reset  = 1'b1;
        i_target = 5'd0;
        cycle(1'b0);
        n_tests++;
        if (o_duty !== 5'd0 || o_busy !== 1'b0 || o_at_target !== 1'b0 || o_state !== S_HOLD) begin
            n_fail++;
            $display("FAIL reset_values: duty=%0d busy=%b at=%b state=%0d, expected 0/0/0/HOLD",
                     o_duty, o_busy, o_at_target, o_state);
        end
        i_reset = 1'b0;
        cycle(1'b0);
        n_tests++;
        if (o_at_target !== 1'b1 || o_state !== S_HOLD || o_duty !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_release_at_target: at=%b state=%0d duty=%0d, expected 1/HOLD/0",
                     o_at_target, o_state, o_duty);
        end
    endtask

    task automatic test_ramp_up();
        logic [SIZE-1:0] exp_seq [4];
        logic [SIZE-1:0] prev;
        exp_seq = '{5'd3, 5'd6, 5'd9, 5'd10};
        do_reset();
        i_target = 5'd10;
        cycle(1'b0);
        n_tests++;
        if (o_state !== S_UP || o_busy !== 1'b1 || o_duty !== 5'd0 || o_at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_entry: state=%0d busy=%b duty=%0d at=%b, expected UP/1/0/0",
                     o_state, o_busy, o_duty, o_at_target);
        end
        prev = 5'd0;
        for (int k = 0; k < 4; k++) begin
            // First synch of the pair: no change yet.
            cycle(1'b1);
            n_tests++;
            if (o_duty !== prev || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL ramp_mid_step%0d: duty=%0d busy=%b, expected %0d/1",
                         k, o_duty, o_busy, prev);
            end
            repeat (9) cycle(1'b0);
            // Second synch: duty changes on this edge.
            cycle(1'b1);
            n_tests++;
            if (o_duty !== exp_seq[k]) begin
                n_fail++;
                $display("FAIL ramp_duty_step%0d: duty=%0d, expected %0d", k, o_duty, exp_seq[k]);
            end
            n_tests++;
            if (k < 3) begin
                if (o_busy !== 1'b1 || o_at_target !== 1'b0 || o_state !== S_UP) begin
                    n_fail++;
                    $display("FAIL ramp_flags_step%0d: busy=%b at=%b state=%0d, expected 1/0/UP",
                             k, o_busy, o_at_target, o_state);
                end
            end else begin
                if (o_busy !== 1'b0 || o_at_target !== 1'b1 || o_state !== S_HOLD) begin
                    n_fail++;
                    $display("FAIL ramp_final_flags: busy=%b at=%b state=%0d, expected 0/1/HOLD",
                             o_busy, o_at_target, o_state);
                end
            end
            prev = exp_seq[k];
            repeat (9) cycle(1'b0);
        end
    endtask

    task automatic test_clamp();
        do_reset();
        i_target = 5'd31;
        cycle(1'b0);
        pulses(20);
        n_tests++;
        if (o_duty !== 5'd30 || o_state !== S_UP) begin
            n_fail++;
            $display("FAIL clamp_reach30: duty=%0d state=%0d, expected 30/UP", o_duty, o_state);
        end
        pulses(2);
        n_tests++;
        if (o_duty !== 5'd31 || o_state !== S_HOLD || o_at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_up_31: duty=%0d state=%0d at=%b, expected 31/HOLD/1",
                     o_duty, o_state, o_at_target);
        end
        // 31 down to 2: 28,25,...,4 then clamp to 2.
        i_target = 5'd2;
        cycle(1'b0);
        pulses(20);
        n_tests++;
        if (o_duty !== 5'd2 || o_state !== S_HOLD) begin
            n_fail++;
            $display("FAIL clamp_down_2: duty=%0d state=%0d, expected 2/HOLD", o_duty, o_state);
        end
        i_target = 5'd0;
        cycle(1'b0);
        n_tests++;
        if (o_state !== S_DOWN || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_enter_down: state=%0d busy=%b, expected DOWN/1", o_state, o_busy);
        end
        pulses(2);
        n_tests++;
        if (o_duty !== 5'd0 || o_state !== S_HOLD || o_at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL clamp_down_0: duty=%0d state=%0d at=%b, expected 0/HOLD/1",
                     o_duty, o_state, o_at_target);
        end
    endtask

    task automatic test_reversal();
        do_reset();
        i_target = 5'd20;
        cycle(1'b0);
        pulses(6);
        n_tests++;
        if (o_duty !== 5'd9 || o_state !== S_UP) begin
            n_fail++;
            $display("FAIL rev_reach9: duty=%0d state=%0d, expected 9/UP", o_duty, o_state);
        end
        i_target = 5'd4;
        cycle(1'b0);
        n_tests++;
        if (o_state !== S_UP || o_duty !== 5'd9) begin
            n_fail++;
            $display("FAIL rev_between_steps: state=%0d duty=%0d, expected UP/9", o_state, o_duty);
        end
        pulses(2);
        n_tests++;
        if (o_state !== S_DOWN || o_duty !== 5'd9 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rev_turn: state=%0d duty=%0d busy=%b, expected DOWN/9/1",
                     o_state, o_duty, o_busy);
        end
        pulses(2);
        n_tests++;
        if (o_duty !== 5'd6 || o_state !== S_DOWN) begin
            n_fail++;
            $display("FAIL rev_step6: duty=%0d state=%0d, expected 6/DOWN", o_duty, o_state);
        end
        pulses(2);
        n_tests++;
        if (o_duty !== 5'd4 || o_state !== S_HOLD || o_at_target !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_land4: duty=%0d state=%0d at=%b busy=%b, expected 4/HOLD/1/0",
                     o_duty, o_state, o_at_target, o_busy);
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        i_target = 5'd20;
        cycle(1'b0);
        pulses(2);
        // One pulse into the next step, then freeze.
        pulses(1);
        i_enable = 1'b0;
        pulses(5);
        n_tests++;
        if (o_duty !== 5'd3 || o_state !== S_UP || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_hold: duty=%0d state=%0d busy=%b, expected 3/UP/1",
                     o_duty, o_state, o_busy);
        end
        i_enable = 1'b1;
        cycle(1'b0);
        // Only one pulse was outstanding before the freeze.
        cycle(1'b1);
        n_tests++;
        if (o_duty !== 5'd6) begin
            n_fail++;
            $display("FAIL freeze_resume_step: duty=%0d, expected 6", o_duty);
        end
    endtask

    task automatic test_stop();
        do_reset();
        i_target = 5'd17;
        cycle(1'b0);
        pulses(12);
        n_tests++;
        if (o_duty !== 5'd17 || o_state !== S_HOLD) begin
            n_fail++;
            $display("FAIL stop_reach17: duty=%0d state=%0d, expected 17/HOLD", o_duty, o_state);
        end
        i_target = 5'd25;
        cycle(1'b0);
        pulses(1);
        // Stop on the cycle that would otherwise step to 20.
        i_stop = 1'b1;
        cycle(1'b1);
        n_tests++;
        if (o_duty !== 5'd0 || o_busy !== 1'b0 || o_state !== S_STOPPED || o_at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_force: duty=%0d busy=%b state=%0d at=%b, expected 0/0/STOPPED/0",
                     o_duty, o_busy, o_state, o_at_target);
        end
        i_stop   = 1'b0;
        i_target = 5'd6;
        cycle(1'b0);
        n_tests++;
        if (o_state !== S_HOLD || o_duty !== 5'd0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_release_hold: state=%0d duty=%0d busy=%b, expected HOLD/0/0",
                     o_state, o_duty, o_busy);
        end
        cycle(1'b0);
        n_tests++;
        if (o_state !== S_UP || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_restart_up: state=%0d busy=%b, expected UP/1", o_state, o_busy);
        end
        pulses(2);
        n_tests++;
        if (o_duty !== 5'd3) begin
            n_fail++;
            $display("FAIL stop_restart_step: duty=%0d, expected 3", o_duty);
        end
        pulses(2);
        n_tests++;
        if (o_duty !== 5'd6 || o_state !== S_HOLD || o_at_target !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_restart_land: duty=%0d state=%0d at=%b, expected 6/HOLD/1",
                     o_duty, o_state, o_at_target);
        end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        i_target = 5'd20;
        cycle(1'b0);
        pulses(8);
        n_tests++;
        if (o_duty !== 5'd12 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_reach12: duty=%0d busy=%b, expected 12/1", o_duty, o_busy);
        end
        i_reset  = 1'b1;
        i_target = 5'd0;
        cycle(1'b1);
        n_tests++;
        if (o_duty !== 5'd0 || o_state !== S_HOLD || o_busy !== 1'b0 || o_at_target !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: duty=%0d state=%0d busy=%b at=%b, expected 0/HOLD/0/0",
                     o_duty, o_state, o_busy, o_at_target);
        end
        i_reset = 1'b0;
        cycle(1'b0);
        n_tests++;
        if (o_at_target !== 1'b1 || o_state !== S_HOLD) begin
            n_fail++;
            $display("FAIL rst_at_target: at=%b state=%0d, expected 1/HOLD", o_at_target, o_state);
        end
    endtask

    // ----------------------------------------------------------- main flow
    initial begin
        n_tests  = 0;
        n_fail   = 0;
        i_reset  = 1'b1;
        i_target = '0;
        i_synch  = 1'b0;
        i_enable = 1'b1;
        i_stop   = 1'b0;
        #1;

        test_reset();
        test_ramp_up();
        test_clamp();
        test_reversal();
        test_enable_freeze();
        test_stop();
        test_reset_mid_ramp();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Slew-rate controller between the data-generator/normaliser chain and the PWM generator. It accepts an unsigned duty target and moves the PWM duty word toward it in fixed-size steps, one step every N PWM periods, using the generator's Synch pulse as timebase. This gives soft-start and soft-stop on the PWM output. It also provides an immediate Stop override.

## Interface
Parameters:
- Size, 5: width of Target and Duty; unsigned only.
- StepSize, 1: duty increment or decrement per step, 1 ≤ StepSize ≤ 2^Size−1.
- StepPeriods, 4: number of Synch pulses per step, ≥ 1.

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  synchronous, active-high.
- Target  in  Size  requested duty, sampled every cycle.
- Synch  in  1  one-cycle pulse from the PWM generator at each PWM period start.
- Enable  in  1  1 = ramping allowed; 0 = freeze Duty at its current value.
- Stop  in  1  level, highest priority; forces Duty to 0.
- Duty  out  Size  duty word driven to the PWM generator Data input.
- Busy  out  1  1 while in UP or DOWN.
- AtTarget  out  1  1 when state is HOLD and Duty == Target.

## Operation
- States: HOLD, UP, DOWN, STOPPED. All outputs are registered.
- Reset values: state HOLD, Duty 0, step counter 0, Busy 0, AtTarget 0.
- Priority per cycle: Reset > Stop > Enable==0 > normal operation.
- Stop = 1 from any state: next state STOPPED, Duty 0, counter 0.
- STOPPED → HOLD on the first cycle with Stop = 0. Duty stays 0; ramping then resumes normally.
- Enable = 0: state, Duty and counter are frozen. Synch pulses are ignored, not counted.
- HOLD, Enable = 1:
  - Target > Duty → UP.
  - Target < Duty → DOWN.
  - Otherwise stay in HOLD.
  - Counter is cleared on entry to UP or DOWN.
- UP/DOWN: each Synch pulse increments the counter. When the counter would reach StepPeriods, it is cleared and a step is taken.
- Step arithmetic uses a Size+1-bit intermediate:
  - UP: Duty = min(Duty + StepSize, Target).
  - DOWN: Duty = max(Duty − StepSize, Target).
  - No overshoot and no wrap-around: with Target 31 and Duty 30, the result is 31, never 1.
- Direction is re-evaluated against the current Target at every step:
  - If Target has crossed below Duty while in UP, the state switches to DOWN with no step taken on that pulse; symmetric for DOWN.
  - If Target == Duty at any cycle in UP or DOWN, next state is HOLD.
- When a step lands on Target, next state is HOLD on the same edge.
- Target changes outside step boundaries never change Duty directly.
- Busy = next state ∈ {UP, DOWN}.
- AtTarget = next state is HOLD and next Duty == current Target.

## Timing
- Duty changes only on the edge following a qualifying Synch pulse. The PWM generator therefore sees the new word before its next period start.
- HOLD→UP/DOWN latency: 1 cycle after Target differs from Duty. Busy rises on the same edge.
- Step latency: exactly StepPeriods Synch pulses after entry to UP or DOWN, then every StepPeriods pulses.
- A Synch pulse that coincides with the entry cycle is not counted.
- Stop asserted at cycle t: Duty = 0 and Busy = 0 visible at t+1, regardless of Synch.
- Stop and a step on the same cycle: Stop wins and no step is taken.
- Reset mid-ramp: all outputs return to reset values on the next edge. AtTarget becomes 1 one cycle later if Target == 0.

## Test plan
- Ramp up (Size 5, StepSize 3, StepPeriods 2), Target 0→10, Synch every 10 cycles → Duty sequence 0,3,6,9,10, with each change on the edge after every 2nd Synch. Busy is high throughout the ramp. AtTarget rises together with Duty = 10.
- Clamp and no-wrap: Duty 30, Target 31, StepSize 3 → Duty 31, never wraps to 1. Then Target 0, StepSize 3, Duty 2 → Duty 0, never wraps to 31.
- Reversal: while ramping up at Duty 9, set Target 4 → on the next step pulse the state becomes DOWN and Duty stays 9. The following steps give 6, then 4, then HOLD.
- Enable low for 5 Synch pulses mid-ramp → Duty is frozen and the counter is unchanged. After Enable returns, the step lands exactly at the remaining count.
- Stop at Duty 17 coinciding with a step pulse → Duty 0 next cycle, Busy 0. Release Stop with Target 6 → HOLD, then UP, then the ramp restarts from 0.
- Synchronous Reset asserted mid-ramp at Duty 12 → Duty 0, state HOLD, Busy 0 on the next edge. With Target = 0, AtTarget becomes 1 one cycle later.
